pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV32 pipeline. Produces PC, IF/ID, ID/EX and EX/MEM

---
 rtl/pipe_hazard_ctrl_if.sv | 41 ++++
 rtl/pipe_hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline hazard inputs and stage enable/flush controls.
// The pipeline drives the master side; the controller sits on the slave side.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       rs1_id;
  logic [4:0]       rs2_id;
  logic             use_rs1_id;
  logic             use_rs2_id;
  logic [4:0]       rd_ex;
  logic             mem_read_ex;
  logic             mispredict_ex;
  logic [31:0]      target_ex;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_en;
  logic             pc_redirect;
  logic [31:0]      redirect_pc;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_flush;
  logic             ex_mem_en;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, mem_read_ex, mispredict_ex,
           target_ex, dmem_req, dmem_ready,
    input  pc_en, pc_redirect, redirect_pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, mem_timeout_err, stall_cycles, flush_events
  );

  modport slave (
    input  rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, mem_read_ex, mispredict_ex,
           target_ex, dmem_req, dmem_ready,
    output pc_en, pc_redirect, redirect_pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, mem_timeout_err, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, mispredict redirects,
// data-memory freezes, wait timeout detection and hazard statistics.
module pipe_hazard_ctrl #(
  parameter int unsigned REDIRECT_CYC = 2,
  parameter int unsigned MEM_TIMEOUT  = 256,
  parameter int unsigned CNT_W        = 32
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int unsigned RcW = $clog2(REDIRECT_CYC + 1);
  localparam int unsigned WcW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [RcW-1:0] RcReload = RcW'(REDIRECT_CYC - 1);
  localparam logic [WcW-1:0] WcMax    = WcW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {StRun, StMemWait, StRedirect} state_e;

  state_e           state_q;
  logic             ret_redir_q;
  logic [RcW-1:0]   redir_cnt_q;
  logic [WcW-1:0]   wait_cnt_q;
  logic             err_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  logic mem_stall, load_use, redir_active;
  logic c_misp, c_lu, c_redir;

  always_comb begin
    mem_stall = hz.dmem_req & ~hz.dmem_ready;
    load_use  = hz.mem_read_ex & (hz.rd_ex != 5'd0) &
                ((hz.use_rs1_id & (hz.rs1_id == hz.rd_ex)) |
                 (hz.use_rs2_id & (hz.rs2_id == hz.rd_ex)));
    // A freeze taken mid-redirect still owes its stale-fetch discard on release.
    redir_active = (state_q == StRedirect) | ((state_q == StMemWait) & ret_redir_q);
    c_misp  = ~mem_stall & hz.mispredict_ex;
    c_lu    = ~mem_stall & ~hz.mispredict_ex & load_use;
    c_redir = ~mem_stall & ~hz.mispredict_ex & ~load_use & redir_active;
  end

  always_comb begin
    hz.pc_en       = 1'b0;
    hz.pc_redirect = 1'b0;
    hz.if_id_en    = 1'b0;
    hz.if_id_flush = 1'b0;
    hz.id_ex_en    = 1'b0;
    hz.id_ex_flush = 1'b0;
    hz.ex_mem_en   = 1'b0;
    if (!rst && !mem_stall) begin
      hz.pc_en       = ~c_lu;
      hz.pc_redirect = c_misp;
      hz.if_id_en    = ~c_lu;
      hz.if_id_flush = c_misp | c_redir;
      hz.id_ex_en    = 1'b1;
      hz.id_ex_flush = c_misp | c_lu;
      hz.ex_mem_en   = 1'b1;
    end
  end

  assign hz.redirect_pc     = hz.target_ex;
  assign hz.mem_timeout_err = err_q;
  assign hz.stall_cycles    = stall_q;
  assign hz.flush_events    = flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      ret_redir_q <= 1'b0;
      redir_cnt_q <= '0;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      stall_q     <= '0;
      flush_q     <= '0;
    end else begin
      if (mem_stall) begin
        state_q <= StMemWait;
        if (state_q == StRedirect) begin
          ret_redir_q <= 1'b1;
        end else if (state_q == StRun) begin
          ret_redir_q <= 1'b0;
        end
      end else if (hz.mispredict_ex) begin
        ret_redir_q <= 1'b0;
        if (REDIRECT_CYC > 1) begin
          state_q     <= StRedirect;
          redir_cnt_q <= RcReload;
        end else begin
          state_q     <= StRun;
          redir_cnt_q <= '0;
        end
      end else if (redir_active) begin
        ret_redir_q <= 1'b0;
        redir_cnt_q <= redir_cnt_q - 1'b1;
        state_q     <= (redir_cnt_q <= RcW'(1)) ? StRun : StRedirect;
      end else begin
        ret_redir_q <= 1'b0;
        state_q     <= StRun;
      end

      if (mem_stall) begin
        if (wait_cnt_q != WcMax) begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
        end
        if (wait_cnt_q >= WcW'(MEM_TIMEOUT - 1)) begin
          err_q <= 1'b1;
        end
      end else begin
        wait_cnt_q <= '0;
      end

      if ((mem_stall | c_lu) && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
      if (c_misp && (flush_q != '1)) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: expected controls are queued with each stimulus cycle
// and compared by a negedge monitor; counters and error flag are checked inline per scenario.
module tb_pipe_hazard_ctrl;
  localparam int unsigned CNT_W = 32;

  // {pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en}
  localparam logic [6:0] C_RUN    = 7'b1010101;
  localparam logic [6:0] C_FROZEN = 7'b0000000;
  localparam logic [6:0] C_MISP   = 7'b1111111;
  localparam logic [6:0] C_LU     = 7'b0000111;
  localparam logic [6:0] C_REDIR  = 7'b1011101;

  typedef struct {
    string      name;
    logic [6:0] ctrl;
    logic [31:0] rpc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipe_hazard_ctrl #(
    .REDIRECT_CYC(2),
    .MEM_TIMEOUT (4),
    .CNT_W       (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ctrl_now();
    return {hz.pc_en, hz.pc_redirect, hz.if_id_en, hz.if_id_flush,
            hz.id_ex_en, hz.id_ex_flush, hz.ex_mem_en};
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (ctrl_now() !== e.ctrl) begin
        failures++;
        $display("FAIL %s ctrl got=%b want=%b", e.name, ctrl_now(), e.ctrl);
      end
      checks++;
      if (hz.redirect_pc !== e.rpc) begin
        failures++;
        $display("FAIL %s redirect_pc got=%h want=%h", e.name, hz.redirect_pc, e.rpc);
      end
    end
  end

  task automatic idle();
    hz.rs1_id = 5'd0; hz.rs2_id = 5'd0; hz.use_rs1_id = 1'b0; hz.use_rs2_id = 1'b0;
    hz.rd_ex = 5'd0; hz.mem_read_ex = 1'b0; hz.mispredict_ex = 1'b0;
    hz.target_ex = 32'h0; hz.dmem_req = 1'b0; hz.dmem_ready = 1'b0;
  endtask

  // Queue the expectation for the cycle just driven, then advance to just past the next edge.
  task automatic drive(input string nm, input logic [6:0] ectrl, input logic [31:0] tgt);
    exp_t e;
    e.name = nm; e.ctrl = ectrl; e.rpc = tgt;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    hz.mispredict_ex = 1'b1; hz.mem_read_ex = 1'b1; hz.rd_ex = 5'd5;
    hz.rs1_id = 5'd5; hz.use_rs1_id = 1'b1; hz.target_ex = 32'h44;
    #2;
    checks++;
    if (ctrl_now() !== C_FROZEN) begin
      failures++; $display("FAIL reset_ctrl got=%b want=%b", ctrl_now(), C_FROZEN);
    end
    checks++;
    if (hz.stall_cycles !== '0 || hz.flush_events !== '0 || hz.mem_timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got=%0d/%0d/%b want=0/0/0",
               hz.stall_cycles, hz.flush_events, hz.mem_timeout_err);
    end
    do_reset();
    drive("reset_run", C_RUN, 32'h0);
  endtask

  task automatic test_load_use();
    do_reset();
    hz.mem_read_ex = 1'b1; hz.rd_ex = 5'd5;
    hz.rs1_id = 5'd5; hz.use_rs1_id = 1'b1; hz.rs2_id = 5'd1; hz.use_rs2_id = 1'b1;
    drive("lu_bubble", C_LU, 32'h0);
    hz.mem_read_ex = 1'b0; hz.rd_ex = 5'd6;
    drive("lu_resume", C_RUN, 32'h0);
    checks++;
    if (hz.stall_cycles !== 32'd1) begin
      failures++; $display("FAIL lu_stall_cnt got=%0d want=1", hz.stall_cycles);
    end
  endtask

  task automatic test_no_hazard();
    do_reset();
    hz.mem_read_ex = 1'b1; hz.rd_ex = 5'd0; hz.rs1_id = 5'd0; hz.use_rs1_id = 1'b1;
    drive("nh_rd_zero", C_RUN, 32'h0);
    hz.rd_ex = 5'd7; hz.rs1_id = 5'd7; hz.use_rs1_id = 1'b0; hz.rs2_id = 5'd3; hz.use_rs2_id = 1'b1;
    drive("nh_no_use", C_RUN, 32'h0);
    hz.rs2_id = 5'd7;
    drive("nh_rs2_match", C_LU, 32'h0);
    checks++;
    if (hz.stall_cycles !== 32'd1) begin
      failures++; $display("FAIL nh_stall_cnt got=%0d want=1", hz.stall_cycles);
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    hz.mispredict_ex = 1'b1; hz.target_ex = 32'h100;
    drive("mp_redirect", C_MISP, 32'h100);
    hz.mispredict_ex = 1'b0; hz.target_ex = 32'h104;
    drive("mp_discard", C_REDIR, 32'h104);
    drive("mp_run", C_RUN, 32'h104);
    checks++;
    if (hz.flush_events !== 32'd1) begin
      failures++; $display("FAIL mp_flush_cnt got=%0d want=1", hz.flush_events);
    end
  endtask

  task automatic test_misp_and_load_use();
    do_reset();
    hz.mispredict_ex = 1'b1; hz.target_ex = 32'h340;
    hz.mem_read_ex = 1'b1; hz.rd_ex = 5'd9; hz.rs1_id = 5'd9; hz.use_rs1_id = 1'b1;
    drive("ml_redirect", C_MISP, 32'h340);
    idle();
    drive("ml_discard", C_REDIR, 32'h0);
    drive("ml_run", C_RUN, 32'h0);
    checks++;
    if (hz.flush_events !== 32'd1 || hz.stall_cycles !== 32'd0) begin
      failures++;
      $display("FAIL ml_counts got=%0d/%0d want=1/0", hz.flush_events, hz.stall_cycles);
    end
  endtask

  task automatic test_mem_wait_misp();
    do_reset();
    hz.dmem_req = 1'b1; hz.dmem_ready = 1'b0; hz.mispredict_ex = 1'b1; hz.target_ex = 32'h200;
    for (int i = 0; i < 3; i++) drive("mw_frozen", C_FROZEN, 32'h200);
    checks++;
    if (hz.flush_events !== 32'd0) begin
      failures++; $display("FAIL mw_no_flush_yet got=%0d want=0", hz.flush_events);
    end
    hz.dmem_ready = 1'b1;
    drive("mw_ready_redirect", C_MISP, 32'h200);
    idle();
    drive("mw_discard", C_REDIR, 32'h0);
    drive("mw_run", C_RUN, 32'h0);
    checks++;
    if (hz.stall_cycles !== 32'd3 || hz.flush_events !== 32'd1) begin
      failures++;
      $display("FAIL mw_counts got=%0d/%0d want=3/1", hz.stall_cycles, hz.flush_events);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    hz.dmem_req = 1'b1; hz.dmem_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      drive("to_frozen", C_FROZEN, 32'h0);
      checks++;
      if (hz.mem_timeout_err !== (i >= 4)) begin
        failures++;
        $display("FAIL to_err_wait%0d got=%b want=%b", i, hz.mem_timeout_err, (i >= 4));
      end
    end
    hz.dmem_ready = 1'b1;
    drive("to_release", C_RUN, 32'h0);
    checks++;
    if (hz.mem_timeout_err !== 1'b1 || hz.stall_cycles !== 32'd6) begin
      failures++;
      $display("FAIL to_sticky got=%b/%0d want=1/6", hz.mem_timeout_err, hz.stall_cycles);
    end
    do_reset();
    checks++;
    if (hz.mem_timeout_err !== 1'b0) begin
      failures++; $display("FAIL to_cleared got=%b want=0", hz.mem_timeout_err);
    end
  endtask

  task automatic test_reset_mid_redirect();
    do_reset();
    hz.mispredict_ex = 1'b1; hz.target_ex = 32'h80;
    drive("rm_redirect", C_MISP, 32'h80);
    idle();
    rst = 1'b1;
    #1;
    checks++;
    if (ctrl_now() !== C_FROZEN || hz.flush_events !== '0) begin
      failures++;
      $display("FAIL rm_async got=%b/%0d want=%b/0", ctrl_now(), hz.flush_events, C_FROZEN);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive("rm_run", C_RUN, 32'h0);
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mispredict();
    test_misp_and_load_use();
    test_mem_wait_misp();
    test_timeout();
    test_reset_mid_redirect();
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL sb_drain got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
